ysyx_25020037_fwd_scoreboard: RTL and testbench

//  Parametrised operand-forwarding scoreboard for the EXU stage. Holds a circular FIFO of in-flight results
//  (issued, not yet committed to the regfile). Gives any number of read ports the youngest in-flight value.

---
 rtl/ysyx_25020037_fwd_scoreboard.sv | 133 +++++++++++++
 tb/tb_ysyx_25020037_fwd_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_fwd_scoreboard.sv
// Operand-forwarding scoreboard: circular FIFO of in-flight results, youngest-match lookup per read port.
// Lookup is combinational on registered state; alloc/fill/retire become visible the cycle after they occur.
module ysyx_25020037_fwd_scoreboard #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int NRP   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    input  logic [4:0]          alloc_rd,
    input  logic [XLEN-1:0]     alloc_data,
    input  logic                alloc_load,
    input  logic                ld_done,
    input  logic [XLEN-1:0]     ld_data,
    input  logic                wb_retire,
    input  logic [NRP*5-1:0]    rs_idx,
    input  logic [NRP*XLEN-1:0] rf_data,
    output logic [NRP*XLEN-1:0] src_data,
    output logic [NRP-1:0]      src_stall,
    output logic                stall,
    output logic [AW:0]         occupancy,
    output logic                proto_err
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_pend;
    logic [4:0]       ent_rd   [DEPTH];
    logic [XLEN-1:0]  ent_data [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   occ;
    logic          perr;

    logic          full;
    logic          retire_ok;
    logic          retire_bad;
    logic          do_alloc;
    logic          fill_hit;
    logic [AW-1:0] fill_idx;

    assign full       = (occ == FULL_CNT);
    assign retire_ok  = wb_retire && ent_valid[head] && !ent_pend[head];
    assign retire_bad = wb_retire && !retire_ok;
    // A rejected retire frees nothing, so a full FIFO must not accept an alloc on it.
    assign alloc_ready = !full || retire_ok;
    assign do_alloc    = alloc_valid && alloc_ready;

    // Oldest valid pending entry, scanning from head.
    always_comb begin
        logic [AW-1:0] idx;
        fill_hit = 1'b0;
        fill_idx = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + AW'(k);
            if (!fill_hit && ent_valid[idx] && ent_pend[idx]) begin
                fill_hit = 1'b1;
                fill_idx = idx;
            end
        end
    end

    // Walk oldest->youngest so a younger match overrides an older one.
    always_comb begin
        logic [AW-1:0] idx;
        logic [4:0]    rsel;
        src_data  = rf_data;
        src_stall = '0;
        idx       = '0;
        rsel      = '0;
        for (int p = 0; p < NRP; p++) begin
            rsel = rs_idx[p*5 +: 5];
            for (int k = 0; k < DEPTH; k++) begin
                idx = head + AW'(k);
                if (ent_valid[idx] && ent_rd[idx] == rsel && rsel != 5'd0) begin
                    src_data[p*XLEN +: XLEN] = ent_data[idx];
                    src_stall[p]             = ent_pend[idx];
                end
            end
        end
    end

    assign stall     = |src_stall;
    assign occupancy = occ;
    assign proto_err = perr;

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            ent_valid <= '0;
            ent_pend  <= '0;
            perr      <= 1'b0;
        end else begin
            if (ld_done) begin
                if (fill_hit) begin
                    ent_pend[fill_idx] <= 1'b0;
                    ent_data[fill_idx] <= ld_data;
                end else begin
                    perr <= 1'b1;
                end
            end
            if (retire_bad) begin
                perr <= 1'b1;
            end
            if (retire_ok) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            // Alloc last: on full alloc+retire it reuses the slot just freed.
            if (do_alloc) begin
                ent_valid[tail] <= 1'b1;
                ent_pend[tail]  <= alloc_load;
                ent_rd[tail]    <= alloc_rd;
                ent_data[tail]  <= alloc_data;
                tail            <= tail + 1'b1;
            end
            case ({do_alloc, retire_ok})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_fwd_scoreboard.sv
// Directed bench: vector table on a DEPTH=4/NRP=2 instance, hand sequences for error stickiness
// and a DEPTH=8/NRP=3 instance exercising pointer wrap and mid-stream reset.
module tb_ysyx_25020037_fwd_scoreboard;

    localparam logic [31:0] RA = 32'hAAAA_0000;
    localparam logic [31:0] RB = 32'hBBBB_0000;
    localparam logic [31:0] RC = 32'hCCCC_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // DUT A: default DEPTH=4, NRP=2
    logic        rst, av, ardy, aload, ld, ret, stl, perr;
    logic [4:0]  ard;
    logic [31:0] adat, lddat;
    logic [9:0]  rs;
    logic [63:0] rf, src;
    logic [1:0]  sst;
    logic [2:0]  occ;

    ysyx_25020037_fwd_scoreboard dut_a (
        .clk(clk), .rst(rst), .alloc_valid(av), .alloc_ready(ardy), .alloc_rd(ard),
        .alloc_data(adat), .alloc_load(aload), .ld_done(ld), .ld_data(lddat),
        .wb_retire(ret), .rs_idx(rs), .rf_data(rf), .src_data(src), .src_stall(sst),
        .stall(stl), .occupancy(occ), .proto_err(perr)
    );

    // DUT B: DEPTH=8, NRP=3
    logic        b_rst, b_av, b_ardy, b_ld, b_ret, b_stl, b_perr;
    logic [4:0]  b_ard;
    logic [31:0] b_adat;
    logic [14:0] b_rs;
    logic [95:0] b_rf, b_src;
    logic [2:0]  b_sst;
    logic [3:0]  b_occ;

    ysyx_25020037_fwd_scoreboard #(.XLEN(32), .DEPTH(8), .NRP(3)) dut_b (
        .clk(clk), .rst(b_rst), .alloc_valid(b_av), .alloc_ready(b_ardy), .alloc_rd(b_ard),
        .alloc_data(b_adat), .alloc_load(1'b0), .ld_done(b_ld), .ld_data(32'h0),
        .wb_retire(b_ret), .rs_idx(b_rs), .rf_data(b_rf), .src_data(b_src), .src_stall(b_sst),
        .stall(b_stl), .occupancy(b_occ), .proto_err(b_perr)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        aload;
        logic        ld;
        logic [31:0] lddat;
        logic        ret;
        logic [4:0]  rs0, rs1;
        logic [31:0] e0, e1;
        logic [1:0]  est;
        logic [2:0]  eocc;
        logic        eardy, eperr;
    } vec_t;

    function automatic vec_t mk(logic a, logic [4:0] r, logic [31:0] d, logic l, logic ldn,
                                logic [31:0] ldd, logic rt, logic [4:0] s0, logic [4:0] s1,
                                logic [31:0] x0, logic [31:0] x1, logic [1:0] st,
                                logic [2:0] oc, logic rdy, logic pe);
        vec_t v;
        v.av = a; v.ard = r; v.adat = d; v.aload = l; v.ld = ldn; v.lddat = ldd; v.ret = rt;
        v.rs0 = s0; v.rs1 = s1; v.e0 = x0; v.e1 = x1; v.est = st; v.eocc = oc;
        v.eardy = rdy; v.eperr = pe;
        return v;
    endfunction

    localparam int NV = 30;
    vec_t vec [NV];

    // Expectations describe outputs before this row's actions take effect at the next edge.
    task automatic fill_table();
        vec[0]  = mk(0,0,0,0, 0,0,0, 1,2, RA,RB,2'b00,0,1,0);
        vec[1]  = mk(1,5,32'h11,0, 0,0,0, 5,0, RA,RB,2'b00,0,1,0);
        vec[2]  = mk(1,5,32'h22,0, 0,0,0, 5,0, 32'h11,RB,2'b00,1,1,0);
        vec[3]  = mk(1,0,32'h33,0, 0,0,0, 5,0, 32'h22,RB,2'b00,2,1,0);
        vec[4]  = mk(0,0,0,0, 0,0,0, 0,5, RA,32'h22,2'b00,3,1,0);
        vec[5]  = mk(1,7,32'h0,1, 0,0,0, 7,7, RA,RB,2'b00,3,1,0);
        vec[6]  = mk(0,0,0,0, 0,0,0, 5,7, 32'h22,32'h0,2'b10,4,0,0);
        vec[7]  = mk(0,0,0,0, 1,32'hDEAD,0, 5,7, 32'h22,32'h0,2'b10,4,0,0);
        vec[8]  = mk(0,0,0,0, 0,0,0, 5,7, 32'h22,32'hDEAD,2'b00,4,0,0);
        vec[9]  = mk(1,9,32'h99,0, 0,0,1, 9,5, RA,32'h22,2'b00,4,1,0);
        vec[10] = mk(0,0,0,0, 0,0,0, 9,5, 32'h99,32'h22,2'b00,4,0,0);
        vec[11] = mk(0,0,0,0, 0,0,1, 9,5, 32'h99,32'h22,2'b00,4,1,0);
        vec[12] = mk(0,0,0,0, 0,0,1, 9,5, 32'h99,RB,2'b00,3,1,0);
        vec[13] = mk(0,0,0,0, 0,0,1, 9,7, 32'h99,32'hDEAD,2'b00,2,1,0);
        vec[14] = mk(1,3,32'h3,1, 0,0,0, 9,7, 32'h99,RB,2'b00,1,1,0);
        vec[15] = mk(1,4,32'h4,1, 0,0,0, 3,4, 32'h3,RB,2'b01,2,1,0);
        vec[16] = mk(1,6,32'h6,1, 1,32'h333,0, 3,4, 32'h3,32'h4,2'b11,3,1,0);
        vec[17] = mk(0,0,0,0, 1,32'h444,0, 3,4, 32'h333,32'h4,2'b10,4,0,0);
        vec[18] = mk(0,0,0,0, 0,0,1, 4,6, 32'h444,32'h6,2'b10,4,1,0);
        vec[19] = mk(0,0,0,0, 1,32'h666,0, 4,6, 32'h444,32'h6,2'b10,3,1,0);
        vec[20] = mk(0,0,0,0, 0,0,1, 4,6, 32'h444,32'h666,2'b00,3,1,0);
        vec[21] = mk(1,8,32'h8,1, 0,0,0, 8,4, RA,32'h444,2'b00,2,1,0);
        vec[22] = mk(0,0,0,0, 0,0,1, 8,4, 32'h8,32'h444,2'b01,3,1,0);
        vec[23] = mk(0,0,0,0, 0,0,1, 8,6, 32'h8,32'h666,2'b01,2,1,0);
        vec[24] = mk(0,0,0,0, 0,0,1, 8,6, 32'h8,RB,2'b01,1,1,0);
        vec[25] = mk(0,0,0,0, 0,0,0, 8,6, 32'h8,RB,2'b01,1,1,1);
        vec[26] = mk(0,0,0,0, 1,32'h888,1, 8,6, 32'h8,RB,2'b01,1,1,1);
        vec[27] = mk(0,0,0,0, 0,0,1, 8,6, 32'h888,RB,2'b00,1,1,1);
        vec[28] = mk(0,0,0,0, 1,32'h999,1, 8,6, RA,RB,2'b00,0,1,1);
        vec[29] = mk(0,0,0,0, 0,0,0, 8,0, RA,RB,2'b00,0,1,1);
    endtask

    task automatic idle_a();
        av = 0; ard = 0; adat = 0; aload = 0; ld = 0; lddat = 0; ret = 0;
    endtask

    task automatic idle_b();
        b_av = 0; b_ard = 0; b_adat = 0; b_ld = 0; b_ret = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_a();
        idle_b();
        rst = 1; b_rst = 1;
        rs = {5'd2, 5'd1}; rf = {RB, RA};
        b_rs = '0; b_rf = {RC, RB, RA};
        fill_table();
        repeat (2) @(negedge clk);
        rst = 0; b_rst = 0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            av = vec[i].av; ard = vec[i].ard; adat = vec[i].adat; aload = vec[i].aload;
            ld = vec[i].ld; lddat = vec[i].lddat; ret = vec[i].ret;
            rs = {vec[i].rs1, vec[i].rs0};
            #1;
            chk($sformatf("v%0d src0", i), src[31:0], vec[i].e0);
            chk($sformatf("v%0d src1", i), src[63:32], vec[i].e1);
            chk($sformatf("v%0d src_stall", i), 32'(sst), 32'(vec[i].est));
            chk($sformatf("v%0d stall", i), 32'(stl), 32'(|vec[i].est));
            chk($sformatf("v%0d occupancy", i), 32'(occ), 32'(vec[i].eocc));
            chk($sformatf("v%0d alloc_ready", i), 32'(ardy), 32'(vec[i].eardy));
            chk($sformatf("v%0d proto_err", i), 32'(perr), 32'(vec[i].eperr));
        end

        // Reset clears sticky error; ld_done with nothing pending sets it.
        @(negedge clk); idle_a(); rst = 1;
        @(negedge clk); rst = 0; #1;
        chk("rst clears proto_err", 32'(perr), 32'd0);
        ld = 1; lddat = 32'h5;
        @(negedge clk); ld = 0; #1;
        chk("stray ld_done proto_err", 32'(perr), 32'd1);
        @(negedge clk); #1;
        chk("stray ld_done sticky", 32'(perr), 32'd1);
        rst = 1;
        @(negedge clk); rst = 0; ret = 1;
        @(negedge clk); ret = 0; #1;
        chk("empty retire proto_err", 32'(perr), 32'd1);
        chk("empty retire occupancy", 32'(occ), 32'd0);

        // DEPTH=8 NRP=3: three ports hit distinct entries across pointer wrap.
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); idle_b(); b_av = 1; b_ard = 5'(i); b_adat = 32'h100 + 32'(i);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle_b(); b_ret = 1;
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); idle_b(); b_av = 1; b_ard = 5'(10 + j); b_adat = 32'h200 + 32'(j);
        end
        @(negedge clk); idle_b();
        b_rs = {5'd13, 5'd11, 5'd6}; #1;
        chk("wrap port0 x6", b_src[31:0], 32'h106);
        chk("wrap port1 x11", b_src[63:32], 32'h201);
        chk("wrap port2 x13", b_src[95:64], 32'h203);
        chk("wrap occupancy", 32'(b_occ), 32'd6);
        chk("wrap stall", 32'(b_stl), 32'd0);
        b_rs = {5'd12, 5'd3, 5'd10}; #1;
        chk("wrap port0 x10", b_src[31:0], 32'h200);
        chk("wrap port1 x3 retired", b_src[63:32], RB);
        chk("wrap port2 x12", b_src[95:64], 32'h202);

        // Reset asserted together with an alloc: everything dropped next cycle.
        @(negedge clk); b_rst = 1; b_av = 1; b_ard = 5'd11; b_adat = 32'h777;
        @(negedge clk); b_rst = 0; idle_b(); #1;
        chk("mid rst occupancy", 32'(b_occ), 32'd0);
        chk("mid rst port0", b_src[31:0], RA);
        chk("mid rst port1", b_src[63:32], RB);
        chk("mid rst port2", b_src[95:64], RC);
        chk("mid rst alloc_ready", 32'(b_ardy), 32'd1);
        chk("mid rst stall", 32'(b_stl), 32'd0);
        chk("mid rst proto_err", 32'(b_perr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
